// File: rtl/aes_round_sequencer_if.sv
// Handshake bundle for the AES round sequencer: plaintext/key in, ciphertext out.
// The source/consumer side uses master; the sequencer itself uses slave.
interface aes_round_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_pt;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ct;

  modport master (
    output in_valid, in_pt, in_key, out_ready,
    input  in_ready, out_valid, out_ct
  );

  modport slave (
    input  in_valid, in_pt, in_key, out_ready,
    output in_ready, out_valid, out_ct
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: holds state and round key, steps an external
// one-round datapath NUM_ROUNDS times, then presents the ciphertext.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int RW         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_round_sequencer_if.slave  bus,
  output logic                  busy,
  output logic [127:0]          dp_state,
  output logic [127:0]          dp_key,
  output logic [7:0]            dp_rcon,
  output logic [RW-1:0]         dp_round,
  output logic                  dp_last,
  input  logic [127:0]          dp_key_nxt,
  input  logic [127:0]          dp_state_nxt
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [127:0]  state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  out_ct_q, out_ct_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [RW-1:0] round_q, round_d;
  logic          in_ready;
  logic          out_valid;
  logic          last_round;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  assign last_round = (round_q == RW'(NUM_ROUNDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      key_q    <= '0;
      out_ct_q <= '0;
      rcon_q   <= 8'h01;
      round_q  <= '0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      key_q    <= key_d;
      out_ct_q <= out_ct_d;
      rcon_q   <= rcon_d;
      round_q  <= round_d;
    end
  end

  // Registers hold by default so the dp_* outputs keep their last values in IDLE.
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    key_d    = key_q;
    out_ct_d = out_ct_q;
    rcon_d   = rcon_q;
    round_d  = round_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          state_d = bus.in_pt ^ bus.in_key;
          key_d   = bus.in_key;
          round_d = RW'(1);
          rcon_d  = 8'h01;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = dp_state_nxt;
        key_d   = dp_key_nxt;
        rcon_d  = xtime(rcon_q);
        if (last_round) begin
          out_ct_d = dp_state_nxt;
          fsm_d    = DONE;
        end else begin
          round_d = round_q + RW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // in_ready is also gated by rst so nothing is offered while reset is held.
  always_comb begin
    in_ready  = (fsm_q == IDLE) && !rst;
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q == ROUND) || (fsm_q == DONE);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_ct    = out_ct_q;
  assign dp_state      = state_q;
  assign dp_key        = key_q;
  assign dp_rcon       = rcon_q;
  assign dp_round      = round_q;
  assign dp_last       = last_round;

endmodule
